// File: rtl/riscv_pkg.sv
// Constants shared across the RV32 pipeline: datapath width, canonical NOP,
// and the default boot address.
package riscv_pkg;
    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, used for the fetch queue and the PC tag FIFO.
// Head entry is visible combinationally so a pop and its data share one cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           pushData,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           headData,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic             doPush;
    logic             doPop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign doPop    = pop && !empty;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign doPush   = push && (!full || doPop);
    assign headData = mem[rdPtr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            assert (!(push && !doPush)) else $error("fetch_fifo: push while full");
            if (doPush) wrPtr <= bump(wrPtr);
            if (doPop)  rdPtr <= bump(rdPtr);
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (doPop && !doPush) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtr] <= pushData;
    end
endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: PC generation, valid/ready imem requests, in-order
// response queue with wrong-path discard, and the IF/ID pipeline register.
module fetch_stage #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::DEFAULT_RESET_PC),
    parameter int              FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    output logic            ValidD,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D
);
    import riscv_pkg::*;

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int QW = XLEN + 32;

    logic [XLEN-1:0] pcF;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflightNext;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   qCount;
    logic [CW-1:0]   tagCount;
    logic            qEmpty, qFull, tagEmpty, tagFull;
    logic [XLEN-1:0] tagPc;
    logic [QW-1:0]   qHead;
    logic            issueOk, reqFire, rspKeep, loadD;

    // Responses still owed are counted against queue space so none can overflow it.
    assign issueOk        = !PCSrcE && (({1'b0, inflight} + {1'b0, qCount}) < (CW+1)'(FQ_DEPTH));
    assign imem_req_valid = rst && issueOk;
    assign imem_req_addr  = pcF;
    assign reqFire        = issueOk && imem_req_ready;
    assign rspKeep        = imem_rsp_valid && !PCSrcE && (drop == '0);
    assign loadD          = !PCSrcE && !StallD && !qEmpty;

    always_comb begin
        inflightNext = inflight;
        if (reqFire && !imem_rsp_valid)      inflightNext = inflight + 1'b1;
        else if (!reqFire && imem_rsp_valid) inflightNext = inflight - 1'b1;
    end

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FQ_DEPTH)) tagFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (reqFire),
        .pushData (pcF),
        .pop      (rspKeep),
        .flush    (PCSrcE),
        .headData (tagPc),
        .count    (tagCount),
        .full     (tagFull),
        .empty    (tagEmpty)
    );

    fetch_fifo #(.WIDTH(QW), .DEPTH(FQ_DEPTH)) fetchQueue (
        .clk      (clk),
        .rst      (rst),
        .push     (rspKeep),
        .pushData ({tagPc, imem_rsp_data}),
        .pop      (loadD),
        .flush    (PCSrcE),
        .headData (qHead),
        .count    (qCount),
        .full     (qFull),
        .empty    (qEmpty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcF      <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            assert (!(rspKeep && tagEmpty)) else $error("fetch_stage: response without tag");
            assert (!(reqFire && tagFull)) else $error("fetch_stage: tag FIFO overrun");
            assert (!(rspKeep && qFull && !loadD)) else $error("fetch_stage: fetch queue overrun");
            // Every outstanding response is either tagged or marked for discard.
            assert (({1'b0, tagCount} + {1'b0, drop}) == {1'b0, inflight})
                else $error("fetch_stage: tag/drop bookkeeping lost");
            inflight <= inflightNext;
            if (PCSrcE) begin
                pcF  <= PCTargetE;
                drop <= inflightNext;
            end else begin
                if (reqFire) pcF <= pcF + XLEN'(4);
                if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ValidD   <= 1'b0;
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (PCSrcE) begin
            ValidD <= 1'b0;
            InstrD <= NOP_INSTR;
        end else if (!StallD) begin
            if (!qEmpty) begin
                ValidD   <= 1'b1;
                InstrD   <= qHead[31:0];
                PCD      <= qHead[QW-1:32];
                PCPlus4D <= qHead[QW-1:32] + XLEN'(4);
            end else begin
                ValidD <= 1'b0;
                InstrD <= NOP_INSTR;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: in-order memory model with variable latency
// and a program-order scoreboard of the instructions decode should receive.
module tb_fetch_stage;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] BOOT_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .StallD         (StallD),
        .ValidD         (ValidD),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } memReq_t;
    memReq_t memQ[$];

    int testsRun = 0;
    int testsFailed = 0;
    int cyc, lastDue, idleCnt;
    int unsigned latMin, latMax, readyPct, stallPct, redirPct;
    logic [31:0] expPc, reqExp, bpAddr;
    logic [31:0] savedPcd, savedPc4, savedInstr;
    logic        savedValid;
    logic        phase1, justReleased, redirPrev, stallPrev, bpPrev, bpActive;
    logic        bpArmed, redirArmed, bothArmed;
    int          bpCnt, stallLeft, stallIdx;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check_val("rst_validd", 32'(ValidD), 32'h0);
        check_val("rst_instrd", InstrD, NOP);
        check_val("rst_pcd", PCD, 32'h0);
        check_val("rst_pcplus4d", PCPlus4D, 32'h0);
        check_val("rst_req_valid", 32'(imem_req_valid), 32'h0);
        memQ.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_req_ready = 1'b1;
        PCSrcE = 1'b0;
        PCTargetE = 32'h0;
        StallD = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cyc = 0; lastDue = 0; idleCnt = 0;
        expPc = BOOT_PC; reqExp = BOOT_PC;
        justReleased = 1'b1;
        redirPrev = 1'b0; stallPrev = 1'b0; bpPrev = 1'b0; bpActive = 1'b0;
        bpCnt = 0; stallLeft = 0; stallIdx = 0;
        $display("[TB] reset released");
    endtask

    task automatic sample_cycle();
        int d;
        @(negedge clk);
        if (justReleased) begin
            check_val("first_req_valid", 32'(imem_req_valid), 32'h1);
            check_val("first_req_addr", imem_req_addr, BOOT_PC);
            justReleased = 1'b0;
        end
        if (phase1) begin
            check_val("l1_validd", 32'(ValidD), 32'(cyc >= 3));
            if (cyc >= 3) check_val("l1_pcd", PCD, 32'((cyc - 3) * 4));
        end
        if (redirPrev) begin
            check_val("redir_validd", 32'(ValidD), 32'h0);
            check_val("redir_instrd", InstrD, NOP);
        end
        if (stallPrev) begin
            check_val("stall_validd", 32'(ValidD), 32'(savedValid));
            check_val("stall_pcd", PCD, savedPcd);
            check_val("stall_pcplus4d", PCPlus4D, savedPc4);
            check_val("stall_instrd", InstrD, savedInstr);
        end
        if (bpPrev && !PCSrcE) begin
            check_val("bp_hold_valid", 32'(imem_req_valid), 32'h1);
            check_val("bp_hold_addr", imem_req_addr, bpAddr);
        end
        if (bpActive) check_val("bp_addr8", imem_req_addr, 32'h8);
        if (stallIdx == 6) check_val("stall_req_throttle", 32'(imem_req_valid), 32'h0);
        if (!ValidD) check_val("bubble_is_nop", InstrD, NOP);
        if (imem_req_valid && imem_req_ready) begin
            check_val("req_addr", imem_req_addr, reqExp);
            reqExp = reqExp + 32'd4;
            d = cyc + int'($urandom_range(latMin, latMax));
            if (d <= lastDue) d = lastDue + 1;
            lastDue = d;
            memQ.push_back('{addr: imem_req_addr, due: d});
        end
        idleCnt++;
        if (PCSrcE) begin
            check_val("redir_req_valid", 32'(imem_req_valid), 32'h0);
            $display("[TB] redirect to 0x%08h stall=%0d", PCTargetE, StallD);
            expPc = PCTargetE;
            reqExp = PCTargetE;
        end else if (ValidD && !StallD) begin
            check_val("d_pc", PCD, expPc);
            check_val("d_instr", InstrD, instrOf(expPc));
            check_val("d_pcplus4", PCPlus4D, expPc + 32'd4);
            $display("[TB] decode pc=0x%08h instr=0x%08h", PCD, InstrD);
            expPc = expPc + 32'd4;
            idleCnt = 0;
        end
        check_val("progress", 32'(idleCnt < 100), 32'h1);
        redirPrev  = PCSrcE;
        stallPrev  = StallD && !PCSrcE;
        savedValid = ValidD; savedPcd = PCD; savedPc4 = PCPlus4D; savedInstr = InstrD;
        bpPrev     = imem_req_valid && !imem_req_ready && !PCSrcE;
        bpAddr     = imem_req_addr;
    endtask

    task automatic drive_next();
        @(posedge clk);
        #1;
        cyc++;
        if (memQ.size() > 0 && memQ[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instrOf(memQ[0].addr);
            memQ.delete(0);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        if (bpArmed && imem_req_addr == 32'h8) begin
            bpCnt = 3;
            bpArmed = 1'b0;
        end
        bpActive = (bpCnt > 0);
        if (bpCnt > 0) begin
            imem_req_ready = 1'b0;
            bpCnt--;
        end else begin
            imem_req_ready = ($urandom_range(0, 99) < readyPct);
        end
        if (stallLeft > 0) begin
            StallD = 1'b1;
            stallIdx = 7 - stallLeft;
            stallLeft--;
        end else begin
            StallD = ($urandom_range(0, 99) < stallPct);
            stallIdx = 0;
        end
        PCSrcE = ($urandom_range(0, 99) < redirPct);
        PCTargetE = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0
                  : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        if (redirArmed && memQ.size() >= 2) begin
            PCSrcE = 1'b1;
            PCTargetE = 32'h100;
            redirArmed = 1'b0;
        end
        if (bothArmed) begin
            PCSrcE = 1'b1;
            StallD = 1'b1;
            PCTargetE = 32'h200;
            bothArmed = 1'b0;
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            sample_cycle();
            drive_next();
        end
    endtask

    initial begin
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        PCSrcE = 1'b0; PCTargetE = 32'h0; StallD = 1'b0;
        bpArmed = 1'b0; redirArmed = 1'b0; bothArmed = 1'b0;
        latMin = 1; latMax = 1; readyPct = 100; stallPct = 0; redirPct = 0;
        cyc = 0;

        phase1 = 1'b1;
        do_reset();
        run_cycles(14);
        phase1 = 1'b0;

        do_reset();
        bpArmed = 1'b1;
        run_cycles(20);

        stallLeft = 6;
        run_cycles(20);

        latMin = 3; latMax = 3;
        run_cycles(8);
        redirArmed = 1'b1;
        run_cycles(20);

        latMin = 1; latMax = 1;
        run_cycles(6);
        bothArmed = 1'b1;
        run_cycles(15);

        latMin = 1; latMax = 4; readyPct = 70; stallPct = 20; redirPct = 4;
        run_cycles(700);
        do_reset();
        run_cycles(700);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
